mainmenu_select_controller: RTL and testbench
=============================================

# mainmenu_select_controller

Sequential front end for the main-menu screen. Synchronizes and debounces five raw push-button inputs and walks a 5-entry, 2-column menu cursor. Drives the 3-bit selection index consumed by the main-menu VGA processor as `metadata[28:26]`, and issues a one-cycle launch pulse with the chosen mode when the player confirms.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000, consecutive synchronized-high cycles needed to accept a press. This is 10 ms at 50 MHz. Legal range is 2..2^20-1.
- `CNT_W`, 20, debounce counter width. Must hold `DEBOUNCE_CYCLES`.

Ports:
- `clock`  in  1  system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `menu_enable`  in  1  high while the main menu screen is shown.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_select`  in  1 each  raw, asynchronous, active-high buttons.
- `sel`  out  3  cursor index, feeds `metadata[28:26]`. Encoding:
  - 0 = PLAY 1P, column 0 row 0
  - 1 = ENDLESS, column 0 row 1
  - 2 = PLAY 2P, column 0 row 2
  - 3 = TOP 1P, column 1 row 0
  - 4 = TOP END, column 1 row 1
- `start`  out  1  one-cycle launch pulse.
- `mode`  out  3  value of `sel` captured at launch. Held until the next launch or reset.
- `busy`  out  1  high in LAUNCH and WAIT_EXIT.

## Operation
Input conditioning, per button:
- 2-flop synchronizer produces `s`.
- Counter `cnt` clears when `s`=0. It increments while `s`=1 and saturates at `DEBOUNCE_CYCLES`.
- Press event `ev` is a registered one-cycle pulse, set on the edge where `cnt` goes from `DEBOUNCE_CYCLES-1` to `DEBOUNCE_CYCLES`.
- Exactly one event per press. No auto-repeat.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no event.

Arbitration:
- If several events are asserted in the same cycle, only the highest-priority one is acted on: select > up > down > left > right.
- The others are discarded.

FSM states:
- DISABLED (reset state)
  - `sel` is held.
  - Events are ignored.
  - On `menu_enable`=1, go to BROWSE and set `sel` to 0.
- BROWSE
  - Navigation:
    - up: 0→2, 1→0, 2→1, 3→4, 4→3 (wraps within the column).
    - down: 0→1, 1→2, 2→0, 3→4, 4→3.
    - right: 0→3, 1→4, 2→4.
    - left: 3→0, 4→1.
    - right in column 1, or left in column 0: no change.
  - select: latch `mode`=`sel` and go to LAUNCH.
  - `menu_enable`=0: go to DISABLED. This has priority over any event in the same cycle.
- LAUNCH
  - `start`=1 for this single cycle.
  - Unconditionally go to WAIT_EXIT.
- WAIT_EXIT
  - All events are ignored.
  - On `menu_enable`=0, go to DISABLED.

Rules:
- `sel` never holds a value above 4. If an illegal value is ever present, the next navigation event forces it to 0.
- Debounce counters keep running in every state. A button held through a state change does not generate a second event.

## Timing
Reset values (asynchronous):
- `sel`=0, `mode`=0, `start`=0, `busy`=0, state=DISABLED.
- All synchronizers, counters and `ev` registers are 0.

Latency and timing rules:
- Button latency: raw input first sampled high at edge k gives `ev` high after edge k+1+`DEBOUNCE_CYCLES`. `sel` or state updates at edge k+2+`DEBOUNCE_CYCLES`. The total is `DEBOUNCE_CYCLES`+2 edges after first sampling.
- `start` and `busy` are registered and go high on the same edge the FSM enters LAUNCH. `start` drops on the next edge; `busy` stays high through WAIT_EXIT.
- `menu_enable` is already synchronous and takes effect on the next edge.
- Reset mid-operation:
  - Everything returns immediately to reset values.
  - A button still held after reset release must first fill `cnt` again, so its event fires `DEBOUNCE_CYCLES` cycles after `s` is high again.
- Re-entry from DISABLED always restarts with `sel`=0.

## Test plan
Run the bench with `DEBOUNCE_CYCLES`=4.
- Reset, `menu_enable`=1, hold `btn_down` high for 10 cycles → `sel` goes 0→1 exactly 6 edges after first sampling, one step only. Release, press again → `sel`=2. Press again → `sel`=0 (wrap).
- From `sel`=2, press right → `sel`=4. Press right → `sel`=4. Press left → `sel`=1. Press up twice → `sel` steps 0, then 2.
- Pulse `btn_up` high for 3 cycles → `sel` unchanged, since the glitch is shorter than the debounce window.
- Make `btn_select` and `btn_down` cross threshold in the same cycle with `sel`=3 → `start`=1 for one cycle, `mode`=3, `busy`=1, `sel` stays 3. Further presses are ignored until `menu_enable`=0. Re-enabling gives `sel`=0 with `mode` still 3.
- In BROWSE, deassert `menu_enable` in the same cycle as a select event → state DISABLED, `start` stays 0.
- Assert `reset` while in WAIT_EXIT with `btn_left` held → all outputs 0 at once. After release, no event before 4 cycles of synchronized high.

Source files
------------

// File: rtl/mainmenu_select_controller.sv
// Main-menu front end: conditions five raw buttons (2-flop sync + saturating
// debounce counter + one-shot press event) and walks a 5-entry, 2-column
// cursor. A confirmed selection emits a one-cycle start pulse and latches
// the chosen entry into mode.
//
// Handshake: start is a single-cycle strobe with no back-pressure; the
// consumer must sample mode on the cycle start is high (mode stays valid
// afterwards until the next launch or reset). busy marks the launched
// period (LAUNCH and WAIT_EXIT) and clears only once menu_enable drops.
module mainmenu_select_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       menu_enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  output logic [2:0] sel,
  output logic       start,
  output logic [2:0] mode,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Button bit positions inside the raw/event vectors.
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_SEL   = 4;

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE  = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_DISABLED  = 2'd0;
  localparam logic [1:0] S_BROWSE    = 2'd1;
  localparam logic [1:0] S_LAUNCH    = 2'd2;
  localparam logic [1:0] S_WAIT_EXIT = 2'd3;

  logic [4:0] raw;
  logic [4:0] ev;
  logic [1:0] state;
  logic [1:0] next_state;
  logic [2:0] sel_nxt;
  logic [2:0] mode_nxt;

  assign raw = {btn_select, btn_right, btn_left, btn_down, btn_up};
  assign dbg_state = state;

  // Per-button conditioning: the counter only counts unbroken synchronized
  // high time, so the fire condition (D-1 -> D) is crossed once per press.
  for (genvar i = 0; i < 5; i++) begin : g_btn
    logic             sync_a;
    logic             sync_s;
    logic [CNT_W-1:0] cnt;
    logic             ev_q;

    // Synchronizer, saturating debounce counter and registered press pulse.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync_a <= 1'b0;
        sync_s <= 1'b0;
        cnt    <= '0;
        ev_q   <= 1'b0;
      end else begin
        sync_a <= raw[i];
        sync_s <= sync_a;
        if (!sync_s) begin
          cnt <= '0;
        end else if (cnt != CNT_SAT) begin
          cnt <= cnt + 1'b1;
        end
        ev_q <= sync_s && (cnt == CNT_FIRE);
      end
    end

    assign ev[i] = ev_q;
  end

  // Cursor movement table; any out-of-range index collapses to entry 0.
  function automatic logic [2:0] nav_step(input logic [2:0] cur, input int dir);
    logic [2:0] r;
    r = 3'd0;
    case (dir)
      B_UP: begin
        case (cur)
          3'd0: r = 3'd2;
          3'd1: r = 3'd0;
          3'd2: r = 3'd1;
          3'd3: r = 3'd4;
          3'd4: r = 3'd3;
          default: r = 3'd0;
        endcase
      end
      B_DOWN: begin
        case (cur)
          3'd0: r = 3'd1;
          3'd1: r = 3'd2;
          3'd2: r = 3'd0;
          3'd3: r = 3'd4;
          3'd4: r = 3'd3;
          default: r = 3'd0;
        endcase
      end
      B_LEFT: begin
        case (cur)
          3'd0, 3'd1, 3'd2: r = cur;
          3'd3: r = 3'd0;
          3'd4: r = 3'd1;
          default: r = 3'd0;
        endcase
      end
      default: begin
        case (cur)
          3'd0: r = 3'd3;
          3'd1: r = 3'd4;
          3'd2: r = 3'd4;
          3'd3, 3'd4: r = cur;
          default: r = 3'd0;
        endcase
      end
    endcase
    return r;
  endfunction

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_DISABLED;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; menu_enable dropping beats any same-cycle event.
  always_comb begin
    next_state = state;
    case (state)
      S_DISABLED:  if (menu_enable) next_state = S_BROWSE;
      S_BROWSE: begin
        if (!menu_enable) begin
          next_state = S_DISABLED;
        end else if (ev[B_SEL]) begin
          next_state = S_LAUNCH;
        end
      end
      S_LAUNCH:    next_state = S_WAIT_EXIT;
      S_WAIT_EXIT: if (!menu_enable) next_state = S_DISABLED;
      default:     next_state = S_DISABLED;
    endcase
  end

  // Next values of cursor and mode; one event acted on, select > up > down > left > right.
  always_comb begin
    sel_nxt  = sel;
    mode_nxt = mode;
    case (state)
      S_DISABLED: if (menu_enable) sel_nxt = 3'd0;
      S_BROWSE: begin
        if (menu_enable) begin
          if (ev[B_SEL]) begin
            mode_nxt = sel;
          end else if (ev[B_UP]) begin
            sel_nxt = nav_step(sel, B_UP);
          end else if (ev[B_DOWN]) begin
            sel_nxt = nav_step(sel, B_DOWN);
          end else if (ev[B_LEFT]) begin
            sel_nxt = nav_step(sel, B_LEFT);
          end else if (ev[B_RIGHT]) begin
            sel_nxt = nav_step(sel, B_RIGHT);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; start/busy rise on the same edge the FSM enters LAUNCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel   <= 3'd0;
      mode  <= 3'd0;
      start <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sel   <= sel_nxt;
      mode  <= mode_nxt;
      start <= (next_state == S_LAUNCH);
      busy  <= (next_state == S_LAUNCH) || (next_state == S_WAIT_EXIT);
    end
  end

endmodule

// File: tb/tb_mainmenu_select_controller.sv
// Bench for mainmenu_select_controller with DEBOUNCE_CYCLES = 4: hand-written
// latency/corner sequences, a table of press records, then random stimulus
// compared against a behavioural model of the menu.
module tb_mainmenu_select_controller;

  localparam int D = 4;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_SEL   = 5'b10000;

  logic       clock;
  logic       reset;
  logic       menu_enable;
  logic [4:0] btns;
  logic [2:0] sel;
  logic       start;
  logic [2:0] mode;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  mainmenu_select_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clock       (clock),
    .reset       (reset),
    .menu_enable (menu_enable),
    .btn_up      (btns[0]),
    .btn_down    (btns[1]),
    .btn_left    (btns[2]),
    .btn_right   (btns[3]),
    .btn_select  (btns[4]),
    .sel         (sel),
    .start       (start),
    .mode        (mode),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  // A press is accepted once a button has been seen high on D consecutive
  // clock samples; the menu reacts to it three edges after that last sample.
  typedef enum {M_OFF, M_BROWSE, M_LAUNCH, M_WAIT} mphase_t;

  mphase_t    m_ph;
  logic [2:0] m_sel;
  logic [2:0] m_mode;
  int         run [5];
  logic [4:0] p1, p2, p3;
  logic [4:0] fresh_v;

  function automatic int nav(int s, int dir);
    int col;
    int row;
    col = (s >= 3) ? 1 : 0;
    row = col ? s - 3 : s;
    case (dir)
      0: return col ? 3 + ((row + 1) % 2) : (row + 2) % 3;
      1: return col ? 3 + ((row + 1) % 2) : (row + 1) % 3;
      2: return col ? row : s;
      default: return col ? s : 3 + ((row > 1) ? 1 : row);
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 5; b++) run[b] <= 0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      m_ph <= M_OFF;
      m_sel <= 3'd0;
      m_mode <= 3'd0;
    end else begin
      for (int b = 0; b < 5; b++) begin
        if (btns[b]) begin
          if (run[b] <= D) run[b] <= run[b] + 1;
          fresh_v[b] = (run[b] == D - 1);
        end else begin
          run[b] <= 0;
          fresh_v[b] = 1'b0;
        end
      end
      p1 <= fresh_v;
      p2 <= p1;
      p3 <= p2;
      case (m_ph)
        M_OFF: if (menu_enable) begin m_ph <= M_BROWSE; m_sel <= 3'd0; end
        M_BROWSE: begin
          if (!menu_enable) m_ph <= M_OFF;
          else if (p3[4]) begin m_mode <= m_sel; m_ph <= M_LAUNCH; end
          else if (p3[0]) m_sel <= 3'(nav(int'(m_sel), 0));
          else if (p3[1]) m_sel <= 3'(nav(int'(m_sel), 1));
          else if (p3[2]) m_sel <= 3'(nav(int'(m_sel), 2));
          else if (p3[3]) m_sel <= 3'(nav(int'(m_sel), 3));
        end
        M_LAUNCH: m_ph <= M_WAIT;
        default:  if (!menu_enable) m_ph <= M_OFF;
      endcase
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cmp_model();
    check("rand_sel", int'(sel), int'(m_sel));
    check("rand_mode", int'(mode), int'(m_mode));
    check("rand_start", int'(start), (m_ph == M_LAUNCH) ? 1 : 0);
    check("rand_busy", int'(busy), (m_ph == M_LAUNCH || m_ph == M_WAIT) ? 1 : 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic [4:0] b;
    int         hold;
    logic [2:0] e_sel;
    logic [2:0] e_mode;
    logic       e_busy;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic en, logic [4:0] b, int hold,
                              logic [2:0] s, logic [2:0] m, logic bz);
    vec_t v;
    v.en = en; v.b = b; v.hold = hold; v.e_sel = s; v.e_mode = m; v.e_busy = bz;
    return v;
  endfunction

  // Drive one record, release, let the pipeline drain, then compare.
  task automatic apply_vec(input int idx);
    menu_enable = vecs[idx].en;
    btns = vecs[idx].b;
    repeat (vecs[idx].hold) @(negedge clock);
    btns = B_NONE;
    repeat (6) @(negedge clock);
    check($sformatf("vec%0d_sel", idx), int'(sel), int'(vecs[idx].e_sel));
    check($sformatf("vec%0d_mode", idx), int'(mode), int'(vecs[idx].e_mode));
    check($sformatf("vec%0d_busy", idx), int'(busy), int'(vecs[idx].e_busy));
    check($sformatf("vec%0d_start", idx), int'(start), 0);
  endtask

  // ---------------- driver ----------------
  initial begin
    // browse navigation from sel=1
    vecs[0]  = mk(1'b1, B_DOWN, 6, 3'd2, 3'd0, 1'b0);
    vecs[1]  = mk(1'b1, B_DOWN, 6, 3'd0, 3'd0, 1'b0);
    vecs[2]  = mk(1'b1, B_DOWN, 6, 3'd1, 3'd0, 1'b0);
    vecs[3]  = mk(1'b1, B_DOWN, 6, 3'd2, 3'd0, 1'b0);
    vecs[4]  = mk(1'b1, B_RIGHT, 6, 3'd4, 3'd0, 1'b0);
    vecs[5]  = mk(1'b1, B_RIGHT, 6, 3'd4, 3'd0, 1'b0);
    vecs[6]  = mk(1'b1, B_LEFT, 6, 3'd1, 3'd0, 1'b0);
    vecs[7]  = mk(1'b1, B_UP, 6, 3'd0, 3'd0, 1'b0);
    vecs[8]  = mk(1'b1, B_UP, 6, 3'd2, 3'd0, 1'b0);
    vecs[9]  = mk(1'b1, B_UP, 3, 3'd2, 3'd0, 1'b0);
    vecs[10] = mk(1'b1, B_RIGHT, 6, 3'd4, 3'd0, 1'b0);
    vecs[11] = mk(1'b1, B_UP, 6, 3'd3, 3'd0, 1'b0);
    vecs[12] = mk(1'b1, B_UP | B_LEFT, 6, 3'd4, 3'd0, 1'b0);
    vecs[13] = mk(1'b1, B_DOWN | B_RIGHT, 6, 3'd3, 3'd0, 1'b0);
    // after launch with mode=3: ignored presses, exit, re-entry
    vecs[14] = mk(1'b1, B_DOWN, 6, 3'd3, 3'd3, 1'b1);
    vecs[15] = mk(1'b1, B_SEL, 6, 3'd3, 3'd3, 1'b1);
    vecs[16] = mk(1'b0, B_NONE, 1, 3'd3, 3'd3, 1'b0);
    vecs[17] = mk(1'b1, B_NONE, 1, 3'd0, 3'd3, 1'b0);
    vecs[18] = mk(1'b1, B_RIGHT, 6, 3'd3, 3'd3, 1'b0);
    vecs[19] = mk(1'b1, B_UP, 6, 3'd4, 3'd3, 1'b0);
    // re-entry, navigate to 4 and launch
    vecs[20] = mk(1'b1, B_NONE, 1, 3'd0, 3'd3, 1'b0);
    vecs[21] = mk(1'b1, B_RIGHT, 6, 3'd3, 3'd3, 1'b0);
    vecs[22] = mk(1'b1, B_UP, 6, 3'd4, 3'd3, 1'b0);
    vecs[23] = mk(1'b1, B_SEL, 6, 3'd4, 3'd4, 1'b1);

    reset = 1'b1;
    menu_enable = 1'b0;
    btns = B_NONE;
    repeat (3) @(negedge clock);
    check("rst_sel", int'(sel), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_start", int'(start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(dbg_state), 0);

    reset = 1'b0;
    @(negedge clock);
    check("disabled_idle_state", int'(dbg_state), 0);
    menu_enable = 1'b1;
    @(negedge clock);
    check("enter_browse_state", int'(dbg_state), 1);
    check("enter_browse_sel", int'(sel), 0);

    // Held down for 10 cycles: single step, D+2 edges after first sample.
    btns = B_DOWN;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      check($sformatf("down_latency_e%0d", i), int'(sel), (i >= 7) ? 1 : 0);
    end
    btns = B_NONE;
    repeat (6) @(negedge clock);
    check("down_single_step", int'(sel), 1);

    for (int v = 0; v <= 13; v++) apply_vec(v);

    // select and down cross threshold together at sel=3: select wins.
    btns = B_SEL | B_DOWN;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      check($sformatf("launch_start_e%0d", i), int'(start), (i == 7) ? 1 : 0);
      check($sformatf("launch_busy_e%0d", i), int'(busy), (i >= 7) ? 1 : 0);
      check($sformatf("launch_sel_e%0d", i), int'(sel), 3);
      check($sformatf("launch_mode_e%0d", i), int'(mode), (i >= 7) ? 3 : 0);
    end
    btns = B_NONE;
    repeat (6) @(negedge clock);

    for (int v = 14; v <= 19; v++) apply_vec(v);

    // menu_enable drops on the same edge a select event is acted on.
    btns = B_SEL;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      check($sformatf("drop_start_e%0d", i), int'(start), 0);
      check($sformatf("drop_busy_e%0d", i), int'(busy), 0);
      check($sformatf("drop_state_e%0d", i), int'(dbg_state), (i >= 7) ? 0 : 1);
      if (i == 6) menu_enable = 1'b0;
    end
    btns = B_NONE;
    repeat (6) @(negedge clock);
    check("drop_sel_held", int'(sel), 4);
    check("drop_mode_held", int'(mode), 3);

    for (int v = 20; v <= 23; v++) apply_vec(v);
    check("wait_exit_state", int'(dbg_state), 3);

    // Reset in WAIT_EXIT with left (and down) held through reset.
    btns = B_LEFT | B_DOWN;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_sel", int'(sel), 0);
    check("midrst_mode", int'(mode), 0);
    check("midrst_start", int'(start), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_state", int'(dbg_state), 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      check($sformatf("postrst_sel_e%0d", i), int'(sel), (i >= 7) ? 1 : 0);
    end
    btns = B_NONE;
    repeat (6) @(negedge clock);

    // Random phase against the reference model.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    menu_enable = 1'b1;
    for (int seg = 0; seg < 400; seg++) begin
      int r;
      int hold;
      int pat;
      if ($urandom_range(0, 99) < 3) begin
        reset = 1'b1;
        #1;
        cmp_model();
        @(negedge clock);
        reset = 1'b0;
      end
      if ($urandom_range(0, 99) < 8) menu_enable = ~menu_enable;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        pat = 1 << $urandom_range(0, 4);
      end else if (r < 8) begin
        pat = $urandom_range(0, 31);
      end else begin
        pat = 0;
      end
      btns = 5'(pat);
      hold = $urandom_range(1, 8);
      repeat (hold) begin
        @(negedge clock);
        cmp_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
